nf_uart_tx_strb: RTL and testbench
==================================

// Module: nf_uart_tx_strb
// PURPOSE
//   UART transmitter paced by an external bit-rate enable strobe, e.g. the en output of a clock divider.
//   Sits downstream of the divider: consumes one en pulse per bit period, accepts bytes over a valid/ready handshake,
//   serialises start/data/parity/stop bits LSB first on tx. Single clock domain, no internal rate counter.
// PARAMETERS
//   DATA_W     8  data bits per frame (5..9)
//   PARITY_EN  0  1 = insert parity bit after data
//   PARITY_ODD 0  1 = odd parity, 0 = even (ignored when PARITY_EN=0)
//   STOP_BITS  1  stop bits per frame (1 or 2)
// PORTS
//   clk      in   1       clock
//   reset    in   1       synchronous reset, active-high
//   en       in   1       bit-period strobe, 1-cycle pulse per bit time; may be held high (1 bit/cycle)
//   tx_data  in   DATA_W  byte to send, sampled on handshake
//   tx_valid in   1       tx_data valid
//   tx_ready out  1       block can accept a byte (IDLE only)
//   tx       out  1       serial line, idle high
//   busy     out  1       frame in progress (state != IDLE)
//   done     out  1       1-cycle pulse when last stop bit period completes
// BEHAVIOUR
//   Reset (sync, dominates all): tx=1, tx_ready=1, busy=0, done=0, state=IDLE, shift/counters=0. Mid-frame reset
//     drops the frame; tx=1 on the cycle after reset sampled high.
//   All outputs registered. States: IDLE, ALIGN, START, DATA, PARITY, STOP.
//   IDLE: tx=1. tx_valid&&tx_ready -> latch tx_data into shift reg, compute parity, -> ALIGN; tx_ready=0, busy=1 next cycle.
//     en in IDLE ignored; en coincident with handshake ignored (ALIGN waits for the following en).
//   ALIGN: on en -> tx<=0, -> START. Guarantees full-width start bit aligned to strobe grid.
//   START: on en -> tx<=shift[0], bit_cnt<=0, -> DATA.
//   DATA: on en -> shift right; if bit_cnt==DATA_W-1: tx<=parity, -> PARITY (PARITY_EN) else tx<=1, stop_cnt<=0, -> STOP;
//     else tx<=next bit, bit_cnt++.
//   PARITY: on en -> tx<=1, stop_cnt<=0, -> STOP. Parity = ^data (even) or ~^data (odd).
//   STOP: on en -> if stop_cnt==STOP_BITS-1: done<=1, tx_ready<=1, busy<=0, -> IDLE; else stop_cnt++.
//   tx changes exactly 1 cycle after the en that ends the previous bit; each bit lasts one en period.
//   Frame = 1+DATA_W+PARITY_EN+STOP_BITS en periods after the first en in ALIGN.
//   tx_valid while !tx_ready ignored (no queueing); tx_data may change freely after handshake.
//   Back-to-back: next byte accepted the cycle after done; its start bit begins after the next en, so idle/stop
//     level holds at least one full bit period.
//   bit_cnt width $clog2(DATA_W); stop_cnt 1 bit; counters never wrap inside a frame.
// STRUCTURE
//   nf_uart_pkg: typedef enum logic [2:0] uart_tx_st_t {IDLE,ALIGN,START,DATA,PARITY,STOP};
//     function frame_len(DATA_W,PARITY_EN,STOP_BITS). Shared with a future nf_uart_rx.
//   Single module, no sub-module: one state register block + next-state/output block.
// TESTING
//   8N1, en every 4 clk, send 0xA5 -> tx per bit period: 0,1,0,1,0,0,1,0,1,1; done pulses once; tx_ready low 10 periods + align.
//   PARITY_EN=1, even, 0xA5 -> parity bit 0; PARITY_ODD=1 -> 1; STOP_BITS=2 -> two high periods before done.
//   en held high, 0x3C -> each bit lasts exactly 1 clk; frame 10 clk after ALIGN; done 1 cycle wide.
//   tx_valid held high with 0x01 then 0x80 -> two frames, second start bit >=1 en period after first done; valid during busy ignored.
//   Reset asserted during DATA bit 3 -> next cycle tx=1, tx_ready=1, busy=0, no done; fresh frame afterward correct.
//   en coincident with handshake -> start bit begins at the following en, not the coincident one.

Source files
------------

// File: rtl/nf_uart_pkg.sv
// rtl/nf_uart_pkg.sv - shared UART state encoding and frame-length helper
package nf_uart_pkg;

  // Transmit FSM states. ALIGN waits for the first strobe after a handshake
  // so the start bit always spans a full strobe period.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } uart_tx_st_t;

  // Number of bit periods in one frame: start + data + optional parity + stop.
  function automatic int frame_len(input int data_w, input int parity_en, input int stop_bits);
    return 1 + data_w + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/nf_uart_tx_strb.sv
// rtl/nf_uart_tx_strb.sv - UART transmitter paced by an external bit-rate strobe
//   clk      : clock
//   reset    : synchronous reset, active-high
//   en       : bit-period strobe (one pulse per bit time, may be held high)
//   tx_data  : byte to send, sampled on tx_valid && tx_ready
//   tx_valid : tx_data valid
//   tx_ready : block can accept a byte (idle only)
//   tx       : serial line, idle high
//   busy     : frame in progress
//   done     : one-cycle pulse when the last stop bit period completes
module nf_uart_tx_strb
  import nf_uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int              CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  uart_tx_st_t       state_q,    state_d;
  logic [DATA_W-1:0] shift_q,    shift_d;
  logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              parity_q,   parity_d;
  logic              tx_q,       tx_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    tx_ready_d = tx_ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // A strobe coincident with the handshake is deliberately ignored;
        // ALIGN starts the frame on the next strobe.
        if (tx_valid && tx_ready_q) begin
          shift_d    = tx_data;
          parity_d   = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ALIGN;
        end
      end

      ALIGN: begin
        if (en) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (en) begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end

      DATA: begin
        if (en) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            // shift_q[0] is on the line now; shift_q[1] is the next data bit.
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      PARITY: begin
        if (en) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
      end

      STOP: begin
        if (en) begin
          if (stop_cnt_q == LAST_STOP) begin
            done_d     = 1'b1;
            tx_ready_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end

      default: begin
        tx_d       = 1'b1;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_nf_uart_tx_strb.sv
// tb/tb_nf_uart_tx_strb.sv - directed bench for nf_uart_tx_strb (8N1, 8E1, 8O2 instances)
module tb_nf_uart_tx_strb;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [2:0] tx_w, rdy_w, busy_w, done_w;

  int n_checks;
  int n_fail;

  // capture results: bit p = value seen just after strobe p
  logic [13:0] tx_vec   [3];
  logic [13:0] done_vec [3];
  int          rdy_low  [3];
  int          dones    [3];

  nf_uart_tx_strb #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .en(en), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  nf_uart_tx_strb #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .en(en), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  nf_uart_tx_strb #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_8o2 (
    .clk(clk), .reset(reset), .en(en), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; en = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic sample_cnt();
    for (int i = 0; i < 3; i++) begin
      if (!rdy_w[i]) rdy_low[i]++;
      if (done_w[i]) dones[i]++;
    end
  endtask

  // Handshake one byte, then issue 14 strobes spaced per clocks apart.
  task automatic capture(input logic [7:0] data, input int per);
    @(negedge clk);
    tx_data = data; tx_valid = 1'b1; en = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_vec[i] = '0; done_vec[i] = '0; rdy_low[i] = 0; dones[i] = 0;
    end
    sample_cnt();
    for (int p = 0; p < 14; p++) begin
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      sample_cnt();
      for (int i = 0; i < 3; i++) begin
        tx_vec[i][p]   = tx_w[i];
        done_vec[i][p] = done_w[i];
      end
      for (int c = 1; c < per; c++) begin
        @(negedge clk);
        sample_cnt();
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; tx_valid = 1'b1; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_w !== 3'b111) begin n_fail++; $display("FAIL reset_tx: got %b expected 111", tx_w); end
    n_checks++;
    if (rdy_w !== 3'b111) begin n_fail++; $display("FAIL reset_ready: got %b expected 111", rdy_w); end
    n_checks++;
    if (busy_w !== 3'b000) begin n_fail++; $display("FAIL reset_busy: got %b expected 000", busy_w); end
    n_checks++;
    if (done_w !== 3'b000) begin n_fail++; $display("FAIL reset_done: got %b expected 000", done_w); end
    reset = 1'b0; en = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_8n1();
    apply_reset();
    capture(8'hA5, 4);
    n_checks++;
    if (tx_vec[0] !== 14'h3F4A) begin n_fail++; $display("FAIL 8n1_bits: got %h expected 3f4a", tx_vec[0]); end
    n_checks++;
    if (done_vec[0] !== 14'h0400) begin n_fail++; $display("FAIL 8n1_done_pos: got %h expected 0400", done_vec[0]); end
    n_checks++;
    if (dones[0] !== 1) begin n_fail++; $display("FAIL 8n1_done_count: got %0d expected 1", dones[0]); end
    n_checks++;
    if (rdy_low[0] !== nf_uart_pkg::frame_len(8, 0, 1) * 4 + 1) begin
      n_fail++; $display("FAIL 8n1_ready_low: got %0d expected %0d", rdy_low[0], nf_uart_pkg::frame_len(8, 0, 1) * 4 + 1);
    end
  endtask

  task automatic test_parity();
    apply_reset();
    capture(8'hA5, 4);
    n_checks++;
    if (tx_vec[1] !== 14'h3D4A) begin n_fail++; $display("FAIL even_a5_bits: got %h expected 3d4a", tx_vec[1]); end
    n_checks++;
    if (done_vec[1] !== 14'h0800) begin n_fail++; $display("FAIL even_a5_done: got %h expected 0800", done_vec[1]); end
    n_checks++;
    if (tx_vec[2] !== 14'h3F4A) begin n_fail++; $display("FAIL odd2_a5_bits: got %h expected 3f4a", tx_vec[2]); end
    n_checks++;
    if (done_vec[2] !== 14'h1000) begin n_fail++; $display("FAIL odd2_a5_done: got %h expected 1000", done_vec[2]); end
    n_checks++;
    if (rdy_low[2] !== nf_uart_pkg::frame_len(8, 1, 2) * 4 + 1) begin
      n_fail++; $display("FAIL odd2_ready_low: got %0d expected %0d", rdy_low[2], nf_uart_pkg::frame_len(8, 1, 2) * 4 + 1);
    end
    capture(8'h07, 4);
    n_checks++;
    if (tx_vec[1] !== 14'h3E0E) begin n_fail++; $display("FAIL even_07_bits: got %h expected 3e0e", tx_vec[1]); end
    n_checks++;
    if (tx_vec[2] !== 14'h3C0E) begin n_fail++; $display("FAIL odd2_07_bits: got %h expected 3c0e", tx_vec[2]); end
    n_checks++;
    if (dones[1] !== 1 || dones[2] !== 1) begin
      n_fail++; $display("FAIL parity_done_count: got %0d/%0d expected 1/1", dones[1], dones[2]);
    end
  endtask

  task automatic test_en_held();
    logic [9:0] bits;
    int         early_done;
    apply_reset();
    bits = '0; early_done = 0;
    @(negedge clk);
    tx_data = 8'h3C; tx_valid = 1'b1; en = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n_checks++;
    if (tx_w[0] !== 1'b1) begin n_fail++; $display("FAIL held_align_tx: got %b expected 1", tx_w[0]); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bits[k] = tx_w[0];
      if (done_w[0]) early_done++;
    end
    n_checks++;
    if (bits !== 10'h278) begin n_fail++; $display("FAIL held_bits: got %h expected 278", bits); end
    n_checks++;
    if (early_done !== 0) begin n_fail++; $display("FAIL held_early_done: got %0d expected 0", early_done); end
    @(negedge clk);
    n_checks++;
    if (done_w[0] !== 1'b1) begin n_fail++; $display("FAIL held_done: got %b expected 1", done_w[0]); end
    @(negedge clk);
    n_checks++;
    if (done_w[0] !== 1'b0) begin n_fail++; $display("FAIL held_done_width: got %b expected 0", done_w[0]); end
    repeat (6) @(negedge clk);
    en = 1'b0;
  endtask

  task automatic test_en_coincident();
    apply_reset();
    @(negedge clk);
    tx_data = 8'h00; tx_valid = 1'b1; en = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0; en = 1'b0;
    n_checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b1) begin
      n_fail++; $display("FAIL coinc_after_hs: got tx=%b busy=%b expected tx=1 busy=1", tx_w[0], busy_w[0]);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_w[0] !== 1'b1) begin n_fail++; $display("FAIL coinc_wait_tx: got %b expected 1", tx_w[0]); end
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    n_checks++;
    if (tx_w[0] !== 1'b0) begin n_fail++; $display("FAIL coinc_start_tx: got %b expected 0", tx_w[0]); end
    en = 1'b1;
    repeat (16) @(negedge clk);
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int stray_done;
    apply_reset();
    stray_done = 0;
    @(negedge clk);
    tx_data = 8'h00; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int p = 0; p < 5; p++) begin
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre_reset: got tx=%b busy=%b expected tx=0 busy=1", tx_w[0], busy_w[0]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (tx_w !== 3'b111 || rdy_w !== 3'b111 || busy_w !== 3'b000 || done_w !== 3'b000) begin
      n_fail++; $display("FAIL mid_reset_outs: got tx=%b rdy=%b busy=%b done=%b expected 111 111 000 000",
                         tx_w, rdy_w, busy_w, done_w);
    end
    for (int p = 0; p < 12; p++) begin
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      if (done_w[0] || !tx_w[0]) stray_done++;
      @(negedge clk);
      if (done_w[0] || !tx_w[0]) stray_done++;
    end
    n_checks++;
    if (stray_done !== 0) begin n_fail++; $display("FAIL mid_after_reset_idle: got %0d events expected 0", stray_done); end
    capture(8'h5A, 4);
    n_checks++;
    if (tx_vec[0] !== 14'h3EB4) begin n_fail++; $display("FAIL mid_fresh_bits: got %h expected 3eb4", tx_vec[0]); end
    n_checks++;
    if (done_vec[0] !== 14'h0400) begin n_fail++; $display("FAIL mid_fresh_done: got %h expected 0400", done_vec[0]); end
  endtask

  task automatic test_back_to_back();
    logic [21:0] samp;
    int          np, hs, nd;
    logic        prev_rdy;
    apply_reset();
    samp = '0; np = 0; hs = 0; nd = 0; prev_rdy = 1'b1;
    @(negedge clk);
    tx_data = 8'h01; tx_valid = 1'b1; en = 1'b0;
    for (int cyc = 0; cyc < 88; cyc++) begin
      @(negedge clk);
      if (prev_rdy && !rdy_w[0]) begin
        hs++;
        if (hs == 1) tx_data = 8'h80;
        else tx_valid = 1'b0;
      end
      prev_rdy = rdy_w[0];
      if (done_w[0]) nd++;
      if (en && np < 22) begin
        samp[np] = tx_w[0];
        np++;
      end
      en = ((cyc % 4) == 1);
    end
    en = 1'b0; tx_valid = 1'b0;
    n_checks++;
    if (samp !== 22'h380602) begin n_fail++; $display("FAIL b2b_bits: got %h expected 380602", samp); end
    n_checks++;
    if (hs !== 2) begin n_fail++; $display("FAIL b2b_handshakes: got %0d expected 2", hs); end
    n_checks++;
    if (nd !== 2) begin n_fail++; $display("FAIL b2b_dones: got %0d expected 2", nd); end
    n_checks++;
    if (rdy_w[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_final_ready: got %b expected 1", rdy_w[0]); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; en = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    test_reset();
    test_8n1();
    test_parity();
    test_en_held();
    test_en_coincident();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
